// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32I load/store unit to single-port data memory controller.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module lsu_mem_ctrl #(
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addrs,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t                   state;
  logic [2:0]               f3_q;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic [31:0]              wdata_q;
  logic [31:0]              merge_q;

  logic [31:0] addr_al;
  logic        bad_code;
  logic        req_err;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:MEM_ADDR_BITS];

  // Request decode: illegal codes and (optionally) misalignment become errors.
  always_comb begin
    addr_al = req_addr;
    case (req_funct3[1:0])
      2'b01:   addr_al[0] = 1'b0;
      2'b10:   addr_al[1:0] = 2'b00;
      default: addr_al = req_addr;
    endcase
    if (req_we)
      bad_code = (req_funct3 > 3'b010);
    else
      bad_code = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    req_err = bad_code
           || ((req_funct3[1:0] == 2'b01) && req_addr[0])
           || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    req_err = bad_code;
`endif
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   rd_byte = mem_rd[7:0];
      2'b01:   rd_byte = mem_rd[15:8];
      2'b10:   rd_byte = mem_rd[23:16];
      default: rd_byte = mem_rd[31:24];
    endcase
    rd_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = mem_rd;
    endcase
  end

  always_comb begin
    merged = mem_rd;
    if (f3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00:   merged[7:0]   = wdata_q[7:0];
        2'b01:   merged[15:8]  = wdata_q[7:0];
        2'b10:   merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  assign req_ready = (state == IDLE);
  assign mem_addrs = {{(32-MEM_ADDR_BITS){1'b0}}, addr_q[MEM_ADDR_BITS-1:2], 2'b00};
  assign mem_wd    = (f3_q[1:0] == 2'b10) ? wdata_q : merge_q;
  // Reset must suppress the write at the very edge it is sampled.
  assign mem_we    = (state == WRITE) && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      merge_q    <= 32'd0;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q       <= req_funct3;
            addr_q     <= addr_al[MEM_ADDR_BITS-1:0];
            wdata_q    <= req_wdata;
            resp_err   <= req_err;
            resp_rdata <= 32'd0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_funct3[1:0] == 2'b10) begin
              state <= WRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          merge_q <= merged;
          state   <= WRITE;
        end
        WRITE: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed scoreboard bench for lsu_mem_ctrl.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addrs;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  lsu_mem_ctrl #(.MEM_ADDR_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addrs(mem_addrs), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  logic [31:0] last_wa = 32'd0;

  assign mem_rd = mem[mem_addrs[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addrs[9:2]] <= mem_wd;
      last_wa <= mem_addrs;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input logic eerr, input int elat, input int ewr);
    exp_t e;
    int   w0;
    int   cyc;
    e.rdata = erd;
    e.err   = eerr;
    e.lat   = elat;
    sb.push_back(e);
    w0 = wr_cnt;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5A5A_5A5A;
    chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
    cyc = 1;
    while (!resp_valid && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_latency"}, cyc, e.lat);
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
    chk({tag, "_writes"}, wr_cnt - w0, ewr);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_hold"}, resp_rdata, e.rdata);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int w0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    rst_n = 1'b1;

    do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1);
    chk("sw10_addr", last_wa, 32'h10);
    do_req("lw10", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, 0);

    do_req("sw20z", 1'b1, 3'b010, 32'h20, 32'd0, 32'd0, 1'b0, 2, 1);
    do_req("sh22", 1'b1, 3'b001, 32'h22, 32'h8001, 32'd0, 1'b0, 3, 1);
    chk("sh22_addr", last_wa, 32'h20);
    do_req("lw20a", 1'b0, 3'b010, 32'h20, 32'd0, 32'h80010000, 1'b0, 2, 0);
    do_req("lh22", 1'b0, 3'b001, 32'h22, 32'd0, 32'hFFFF8001, 1'b0, 2, 0);
    do_req("lhu22", 1'b0, 3'b101, 32'h22, 32'd0, 32'h00008001, 1'b0, 2, 0);

    do_req("sw20", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'd0, 1'b0, 2, 1);
    do_req("sb21", 1'b1, 3'b000, 32'h21, 32'h000000AA, 32'd0, 1'b0, 3, 1);
    do_req("lw20b", 1'b0, 3'b010, 32'h20, 32'd0, 32'h1122AA44, 1'b0, 2, 0);
    do_req("lb21", 1'b0, 3'b000, 32'h21, 32'd0, 32'hFFFFFFAA, 1'b0, 2, 0);
    do_req("lbu21", 1'b0, 3'b100, 32'h21, 32'd0, 32'h000000AA, 1'b0, 2, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lw13", 1'b0, 3'b010, 32'h13, 32'd0, 32'd0, 1'b1, 1, 0);
    do_req("lh23", 1'b0, 3'b001, 32'h23, 32'd0, 32'd0, 1'b1, 1, 0);
    do_req("sh23", 1'b1, 3'b001, 32'h23, 32'h7777, 32'd0, 1'b1, 1, 0);
`else
    do_req("lw13", 1'b0, 3'b010, 32'h13, 32'd0, 32'hDEADBEEF, 1'b0, 2, 0);
    do_req("lh23", 1'b0, 3'b001, 32'h23, 32'd0, 32'h00001122, 1'b0, 2, 0);
    do_req("sh23", 1'b1, 3'b001, 32'h23, 32'h7777, 32'd0, 1'b0, 3, 1);
    do_req("lw20c", 1'b0, 3'b010, 32'h20, 32'd0, 32'h7777AA44, 1'b0, 2, 0);
    do_req("sw20r", 1'b1, 3'b010, 32'h20, 32'h1122AA44, 32'd0, 1'b0, 2, 1);
`endif

    do_req("ld011", 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1, 1, 0);
    do_req("st011", 1'b1, 3'b011, 32'h10, 32'h12345678, 32'd0, 1'b1, 1, 0);
    do_req("lw10b", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, 0);

    do_req("sw000", 1'b1, 3'b010, 32'h0, 32'h0BADF00D, 32'd0, 1'b0, 2, 1);
    do_req("lw400", 1'b0, 3'b010, 32'h400, 32'd0, 32'h0BADF00D, 1'b0, 2, 0);

    // Reset lands while the SB sits in WRITE: the write and the response must vanish.
    w0 = wr_cnt;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h20;
    req_wdata  = 32'h00000055;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rstw_we_before", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_we_gated", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstw_writes", wr_cnt - w0, 32'd0);
    chk("rstw_mem", mem[8], 32'h1122AA44);
    @(posedge clk);
    #1;
    chk("rstw_valid2", {31'd0, resp_valid}, 32'd0);
    do_req("lw20d", 1'b0, 3'b010, 32'h20, 32'd0, 32'h1122AA44, 1'b0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 10, byte-address bits decoded by the data memory (1 KiB).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  core request present.
REQ-005 SHALL have port req_ready  output  1  controller can accept a request.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  input  3  RV32I access size/sign code.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  access rejected, qualified by resp_valid.
REQ-013 SHALL have port mem_we  output  1  data-memory write enable.
REQ-014 SHALL have port mem_addrs  output  32  word-aligned address {0, addr[MEM_ADDR_BITS-1:2], 2'b00}.
REQ-015 SHALL have port mem_wd  output  32  data-memory write word.
REQ-016 SHALL have port mem_rd  input  32  data-memory combinational read word.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL accept on req_valid&&req_ready, latching we, funct3, addr, wdata; next state: error->RESP, load->LOAD, SW->WRITE, SB/SH->RMW_RD.
REQ-019 SHALL decode loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU and stores 000 SB, 001 SH, 010 SW; any other code sets resp_err=1 with no memory write.
REQ-020 SHALL, in LOAD, drive mem_addrs with mem_we=0, capture the selected byte/half/word of mem_rd (lane = addr[1:0]), sign-extend for LB/LH, zero-extend for LBU/LHU, then go to RESP.
REQ-021 SHALL, in RMW_RD, capture mem_rd and merge the new byte (lane addr[1:0]) or half (lane addr[1]) into it, then go to WRITE.
REQ-022 SHALL, in WRITE, assert mem_we=1 for exactly one cycle with mem_wd = merged word (SB/SH) or latched wdata (SW), then go to RESP.
REQ-023 SHALL, in RESP, assert resp_valid for exactly one cycle with no backpressure, then return to IDLE.
REQ-024 SHALL give latency from accept edge to resp_valid: error 1 cycle, load 2, SW 2, SB/SH 3.
REQ-025 SHALL hold resp_rdata and resp_err stable from the RESP cycle until the next acceptance.
REQ-026 SHALL ignore req_* inputs outside IDLE; a held req_valid is accepted in the cycle after RESP.
REQ-027 SHALL ignore address bits above MEM_ADDR_BITS-1, so accesses wrap modulo memory size.

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, enter IDLE and clear resp_valid, resp_err, resp_rdata and the merge buffer to 0.
REQ-029 SHALL gate mem_we with rst_n so that a reset asserted during WRITE causes no memory write at that edge.
REQ-030 SHALL abandon any in-flight access on reset without issuing resp_valid.

Configuration
REQ-031 SHALL, when LSU_MISALIGN_TRAP_EN is defined, treat misaligned halfword accesses (addr[0]=1) and word accesses (addr[1:0]!=0) as errors: resp_err=1, resp_rdata=0, no write.
REQ-032 SHALL, when LSU_MISALIGN_TRAP_EN is undefined, force alignment by clearing addr[0] for halfword and addr[1:0] for word accesses, with no misalignment error raised.

Verification
REQ-033 SHALL verify: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_we for 1 cycle at 0x10; LW resp_rdata=0xDEADBEEF 2 cycles after accept.
REQ-034 SHALL verify: word 0x11223344 at 0x20, SB 0x21 data 0xAA -> word 0x1122AA44; LB 0x21 -> 0xFFFFFFAA; LBU 0x21 -> 0x000000AA.
REQ-035 SHALL verify: SH 0x22 data 0x8001 over 0x00000000 -> 0x80010000; LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
REQ-036 SHALL verify: LW 0x13 -> with macro, resp_err=1 after 1 cycle and no write; without macro, reads word at 0x10 with resp_err=0.
REQ-037 SHALL verify: rst_n=0 during the WRITE state of an SB -> no mem_we at that edge, no resp_valid, memory unchanged, req_ready=1 in the next cycle.
REQ-038 SHALL verify: funct3=011 load, and LW 0x400 with MEM_ADDR_BITS=10 -> first gives resp_err=1; second reads word at 0x000.
